mem_read_arbiter: RTL
=====================

Name: mem_read_arbiter

Overview:
- Read-side counterpart of the ingress write arbiter.
- Arbitrates per-port egress (TX) block read requests onto the single packet-buffer memory read port.
- Tags each in-flight read with its port and returns data with a per-port valid strobe after a fixed memory latency.
- Forwards block releases to the free list so drained blocks are recycled.

Parameters:
- NUM_PORTS, 4, number of egress ports (power of two, >=2)
- ADDR_W, 10, block address width
- BLOCK_BITS, 512, bits per memory block
- RD_LATENCY, 1, memory read latency in cycles (>=1) from mem_re_o to valid mem_rdata_i

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_i  in  [NUM_PORTS] x 1  per-port read request; held until granted
- rd_addr_i  in  [NUM_PORTS] x ADDR_W  block address to read; stable while rd_req_i high
- rd_free_i  in  [NUM_PORTS] x 1  qualifies request: release the block to the free list when granted
- rd_gnt_o  out  [NUM_PORTS] x 1  one-hot grant, combinational, same cycle as accepted request
- rd_valid_o  out  [NUM_PORTS] x 1  one-hot data-valid for the owning port
- rd_data_o  out  BLOCK_BITS  read data, shared by all ports, qualified by rd_valid_o
- mem_re_o  out  1  memory read enable
- mem_raddr_o  out  ADDR_W  memory read address
- mem_rdata_i  in  BLOCK_BITS  memory read data, RD_LATENCY after mem_re_o
- fl_free_o  out  1  free-list release strobe
- fl_free_block_idx_o  out  ADDR_W  block index being released

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Arbitration is work-conserving round-robin, not TDM.
  - Priority pointer prio (log2 NUM_PORTS bits).
  - Winner is the first port p with rd_req_i[p]=1, scanning prio, prio+1, ... modulo NUM_PORTS.
  - On a grant to port w, prio <= w+1, wrapping to 0 after NUM_PORTS-1.
  - No request: no grant, prio holds.
- At most one grant per cycle. When granted:
  - rd_gnt_o[w]=1, mem_re_o=1, mem_raddr_o=rd_addr_i[w].
  - All other rd_gnt_o are 0.
  - mem_raddr_o is 0 when mem_re_o=0.
- Requester handshake: the requester keeps req and addr until the cycle it sees gnt. It may drop req, or present a new request, the following cycle.
- Return pipeline: shift register of RD_LATENCY stages, each holding {valid, port}.
  - Stage 0 loads {mem_re_o, w}.
  - When the last stage is valid: rd_valid_o[port]=1 and rd_data_o=mem_rdata_i (combinational pass-through).
  - Otherwise rd_valid_o is all 0 and rd_data_o is don't-care; drive 0.
  - Total request-to-data latency is exactly RD_LATENCY cycles after grant.
  - One read per cycle sustained; back-to-back returns to different ports are legal.
- Free path, registered:
  - fl_free_o <= granted && rd_free_i[w].
  - fl_free_block_idx_o <= rd_addr_i[w].
  - The release appears 1 cycle after grant.
  - The free list accepts every cycle (no backpressure), so one release per cycle max matches one grant per cycle.
- Reset values:
  - prio=0; all pipeline valid bits 0; fl_free_o=0; fl_free_block_idx_o=0.
  - Hence rd_valid_o all 0 and rd_data_o=0.
  - rd_gnt_o and mem_re_o follow inputs combinationally but are forced to 0 while rst=1.
- Reset mid-operation: in-flight reads are discarded. No rd_valid_o is produced for them after reset deasserts, and no pending release is emitted.
- Boundaries:
  - All ports requesting: strict rotation 0,1,2,3,0...
  - Single requester: granted every cycle.
  - prio wrap from NUM_PORTS-1 to 0 is natural modulo.
  - Same address requested by two ports is not detected; this block does not check it.

Decomposition:
- Shared switch package holds ADDR_W, BLOCK_BITS, NUM_PORTS defaults and typedef port_idx_t = logic [$clog2(NUM_PORTS)-1:0], shared with the write arbiter and the address learn table.
- One sub-module: rr_arbiter (req vector in, one-hot gnt plus index out, internal prio pointer, update enable). It is reusable for other multi-port resources.
- Return tag pipeline stays inline.

Test Plan:
1. Reset, then ports 0-3 all request with addrs 0x010/0x020/0x030/0x040 held: grants in order 0,1,2,3 on consecutive cycles, mem_raddr_o matches. With RD_LATENCY=1, rd_valid_o[p] fires the next cycle with the model memory data for each address.
2. Port 2 alone requests addr 0x3FF with rd_free_i=1: gnt[2] same cycle. One cycle later fl_free_o=1 and fl_free_block_idx_o=0x3FF, and rd_valid_o[2]=1 with data from 0x3FF.
3. Fairness after wrap: grant port 3, then ports 0 and 3 request together. Port 0 wins (prio=0), then port 3 next cycle.
4. RD_LATENCY=3 build with back-to-back grants to ports 1,0,1: rd_valid_o returns 1,0,1 exactly 3 cycles after each grant, data matches each address, and there is never more than one valid bit set.
5. Assert rst for 1 cycle while 2 reads are in flight (RD_LATENCY=3): no rd_valid_o and no fl_free_o afterwards, and prio returns to 0 (port 0 wins the next contention).
6. Idle for 10 cycles, then requests from ports 1 and 3: mem_re_o=0 and prio unchanged while idle, then port 1 is granted before port 3.

Source files
------------

// File: rtl/mem_read_arbiter_pkg.sv
// Shared switch definitions: default port count, block geometry and the port index type
// used by the read/write arbiters and the address learn table.
package mem_read_arbiter_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_BLOCK_BITS = 512;
    localparam int DEF_RD_LATENCY = 1;

    typedef logic [$clog2(DEF_NUM_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Per-port egress read bus: requests and addresses in, grants and returned data out.
interface mem_read_arbiter_if
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BLOCK_BITS = DEF_BLOCK_BITS
);

    logic [NUM_PORTS-1:0]             rd_req_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
    logic [NUM_PORTS-1:0]             rd_free_i;
    logic [NUM_PORTS-1:0]             rd_gnt_o;
    logic [NUM_PORTS-1:0]             rd_valid_o;
    logic [BLOCK_BITS-1:0]            rd_data_o;

    modport master (
        output rd_req_i, rd_addr_i, rd_free_i,
        input  rd_gnt_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  rd_req_i, rd_addr_i, rd_free_i,
        output rd_gnt_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Work-conserving round-robin arbiter: one-hot grant plus index, priority pointer
// advances past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand   = '0;
        // N is a power of two, so the candidate index wraps by plain truncation
        for (int k = 0; k < N; k++) begin
            cand = prio_q + IDX_W'(k);
            if (en_i && !any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
        prio_d = any_o ? idx_o + 1'b1 : prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Egress read arbiter: round-robin access to the packet-buffer read port, per-port
// return tagging across the memory latency, and registered block release to the free list.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_read_arbiter_if.slave     rd_bus,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_raddr_o,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic                  fl_free_o,
    output logic [ADDR_W-1:0]     fl_free_block_idx_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] port;
    } tag_t;

    logic [NUM_PORTS-1:0] gnt_vec;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_any;

    // Arbitration is disabled during reset so no grant or memory read escapes it
    rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .en_i  (!rst),
        .req_i (rd_bus.rd_req_i),
        .gnt_o (gnt_vec),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign rd_bus.rd_gnt_o = gnt_vec;
    assign mem_re_o        = gnt_any;
    assign mem_raddr_o     = gnt_any ? rd_bus.rd_addr_i[gnt_idx] : '0;

    tag_t tag_q [RD_LATENCY];
    tag_t tag_d [RD_LATENCY];

    always_comb begin
        tag_d[0] = tag_t'{vld: gnt_any, port: gnt_idx};
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < RD_LATENCY; s++) begin
            if (rst) begin
                tag_q[s] <= '0;
            end else begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    tag_t ret_tag;
    assign ret_tag          = tag_q[RD_LATENCY-1];
    assign rd_bus.rd_data_o = ret_tag.vld ? mem_rdata_i : '0;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
            assign rd_bus.rd_valid_o[gi] = ret_tag.vld && (ret_tag.port == IDX_W'(gi));
        end
    endgenerate

    logic              fl_free_q;
    logic              fl_free_d;
    logic [ADDR_W-1:0] fl_idx_q;
    logic [ADDR_W-1:0] fl_idx_d;

    always_comb begin
        fl_free_d = gnt_any && rd_bus.rd_free_i[gnt_idx];
        fl_idx_d  = gnt_any ? rd_bus.rd_addr_i[gnt_idx] : fl_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fl_free_q <= 1'b0;
            fl_idx_q  <= '0;
        end else begin
            fl_free_q <= fl_free_d;
            fl_idx_q  <= fl_idx_d;
        end
    end

    assign fl_free_o           = fl_free_q;
    assign fl_free_block_idx_o = fl_idx_q;

endmodule
